// File: rtl/dsp_discr_pkg.sv
// Shared types for the I/Q shot discriminator.
//   t_discr_state : FSM encoding used by the shot controller.
//   proj_width()  : width of W_I*I + W_Q*Q with no loss of precision.
//   t_discr_cfg   : one complete configuration record (weights, threshold,
//                   shot length). Field widths follow the default
//                   discriminator widths.
package dsp_discr_pkg;

    localparam int DISCR_IN_W_DEF  = 23;
    localparam int DISCR_WGT_W_DEF = 16;
    localparam int DISCR_MAX_SHOT  = 1024;

    // Each product needs in_w+w_w bits; one extra bit absorbs the carry of
    // the sum so full-scale inputs never wrap.
    function automatic int proj_width(input int in_w, input int w_w);
        return in_w + w_w + 1;
    endfunction

    localparam int DISCR_PROJ_W_DEF = proj_width(DISCR_IN_W_DEF, DISCR_WGT_W_DEF);
    localparam int DISCR_LEN_W_DEF  = $clog2(DISCR_MAX_SHOT + 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        REPORT
    } t_discr_state;

    typedef struct packed {
        logic [DISCR_WGT_W_DEF-1:0]  weight_i;
        logic [DISCR_WGT_W_DEF-1:0]  weight_q;
        logic [DISCR_PROJ_W_DEF-1:0] threshold;
        logic [DISCR_LEN_W_DEF-1:0]  shot_len;
    } t_discr_cfg;

endpackage

// File: rtl/iq_projection_mac.sv
// Three-stage projection/threshold pipeline.
//   S1: I*W_I and Q*W_Q (full precision)
//   S2: sign-extended sum of the two products
//   S3: decision bit = (sum >= threshold)
// Ports: clk, rst (async, active low), in_valid/in_tag/in_i/in_q sample in,
// weight_i/weight_q used at S1, threshold used at S3,
// out_valid/out_tag/out_state decision out.
module iq_projection_mac
    import dsp_discr_pkg::*;
#(
    parameter int IN_W   = 23,
    parameter int W_W    = 16,
    parameter int PROJ_W = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_tag,
    input  logic [IN_W-1:0]   in_i,
    input  logic [IN_W-1:0]   in_q,
    input  logic [W_W-1:0]    weight_i,
    input  logic [W_W-1:0]    weight_q,
    input  logic [PROJ_W-1:0] threshold,
    output logic              out_valid,
    output logic              out_tag,
    output logic              out_state
);

    localparam int PROD_W = IN_W + W_W;

    logic [PROD_W-1:0] prod_i_d, prod_i_q;
    logic [PROD_W-1:0] prod_q_d, prod_q_q;
    logic [PROJ_W-1:0] sum_d, sum_q;
    logic              state_d, state_q;
    logic [2:0]        vld_d, vld_q;
    logic [2:0]        tag_d, tag_q;

    // Operands are widened to the product width first so the multiply is
    // evaluated at full precision without relying on context sizing.
    logic [PROD_W-1:0] ext_in_i, ext_in_q, ext_w_i, ext_w_q;

    always_comb begin
        ext_in_i = {{W_W{in_i[IN_W-1]}}, in_i};
        ext_in_q = {{W_W{in_q[IN_W-1]}}, in_q};
        ext_w_i  = {{IN_W{weight_i[W_W-1]}}, weight_i};
        ext_w_q  = {{IN_W{weight_q[W_W-1]}}, weight_q};

        prod_i_d = $signed(ext_in_i) * $signed(ext_w_i);
        prod_q_d = $signed(ext_in_q) * $signed(ext_w_q);
        sum_d    = {prod_i_q[PROD_W-1], prod_i_q} + {prod_q_q[PROD_W-1], prod_q_q};
        state_d  = $signed(sum_q) >= $signed(threshold);

        vld_d    = {vld_q[1:0], in_valid};
        tag_d    = {tag_q[1:0], in_valid & in_tag};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_i_q <= '0;
            prod_q_q <= '0;
            sum_q    <= '0;
            state_q  <= 1'b0;
            vld_q    <= '0;
            tag_q    <= '0;
        end else begin
            prod_i_q <= prod_i_d;
            prod_q_q <= prod_q_d;
            sum_q    <= sum_d;
            state_q  <= state_d;
            vld_q    <= vld_d;
            tag_q    <= tag_d;
        end
    end

    assign out_valid = vld_q[2];
    assign out_tag   = tag_q[2];
    assign out_state = state_q & vld_q[2];

endmodule

// File: rtl/iq_shot_discriminator.sv
// Projects averaged I/Q samples onto a programmable axis, thresholds each
// projection into a state bit, counts the ones over a triggered shot and
// hands one result record to the host over valid/ready.
// Ports: clk, rst (async, active low); i_valid/i_data_i/i_data_q samples;
// i_cmd_* configuration (captured into shadow on i_cmd_valid);
// i_shot_start trigger; i_ready record accept; o_busy; o_sample_valid/
// o_sample_state per-sample decisions; o_valid/o_ones_cnt/o_majority record;
// o_shot_dropped sticky flag for triggers seen while busy.
module iq_shot_discriminator
    import dsp_discr_pkg::*;
#(
    parameter int INT_IN_DATA_WIDTH = DISCR_IN_W_DEF,
    parameter int INT_WEIGHT_WIDTH  = DISCR_WGT_W_DEF,
    parameter int INT_MAX_SHOT_LEN  = DISCR_MAX_SHOT,
    parameter int INT_PROJ_WIDTH    = proj_width(INT_IN_DATA_WIDTH, INT_WEIGHT_WIDTH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    input  logic [INT_IN_DATA_WIDTH-1:0]          i_data_i,
    input  logic [INT_IN_DATA_WIDTH-1:0]          i_data_q,
    input  logic                                  i_cmd_valid,
    input  logic [INT_WEIGHT_WIDTH-1:0]           i_cmd_weight_i,
    input  logic [INT_WEIGHT_WIDTH-1:0]           i_cmd_weight_q,
    input  logic [INT_PROJ_WIDTH-1:0]             i_cmd_threshold,
    input  logic [$clog2(INT_MAX_SHOT_LEN+1)-1:0] i_cmd_shot_len,
    input  logic                                  i_shot_start,
    input  logic                                  i_ready,
    output logic                                  o_busy,
    output logic                                  o_sample_valid,
    output logic                                  o_sample_state,
    output logic                                  o_valid,
    output logic [$clog2(INT_MAX_SHOT_LEN+1)-1:0] o_ones_cnt,
    output logic                                  o_majority,
    output logic                                  o_shot_dropped
);

    localparam int LEN_W = $clog2(INT_MAX_SHOT_LEN + 1);

    t_discr_state     state_d, state_q;
    t_discr_cfg       shadow_d, shadow_q;
    t_discr_cfg       active_d, active_q;
    t_discr_cfg       cmd_cfg, load_cfg, mac_cfg;
    logic [LEN_W-1:0] ones_d, ones_q;
    logic [LEN_W-1:0] dec_d, dec_q;
    logic [LEN_W-1:0] len_eff;
    logic             dropped_d, dropped_q;
    logic             start_now;
    logic             tag_in;
    logic             s3_valid, s3_tag, s3_state;

    always_comb begin
        cmd_cfg.weight_i  = i_cmd_weight_i;
        cmd_cfg.weight_q  = i_cmd_weight_q;
        cmd_cfg.threshold = i_cmd_threshold;
        cmd_cfg.shot_len  = i_cmd_shot_len;
    end

    // A command arriving together with the trigger wins over the shadow.
    assign load_cfg  = i_cmd_valid ? cmd_cfg : shadow_q;
    assign start_now = (state_q == IDLE) && i_shot_start;

    // The trigger-cycle sample enters S1 before active is updated, so its
    // weights must come from the config being loaded. Its threshold is
    // applied at S3, by which time active already holds the new value.
    assign mac_cfg = start_now ? load_cfg : active_q;
    assign tag_in  = (state_q == COLLECT) || start_now;

    assign len_eff = (active_q.shot_len == '0) ? LEN_W'(1) : active_q.shot_len;

    iq_projection_mac #(
        .IN_W   (INT_IN_DATA_WIDTH),
        .W_W    (INT_WEIGHT_WIDTH),
        .PROJ_W (INT_PROJ_WIDTH)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (i_valid),
        .in_tag    (tag_in),
        .in_i      (i_data_i),
        .in_q      (i_data_q),
        .weight_i  (mac_cfg.weight_i),
        .weight_q  (mac_cfg.weight_q),
        .threshold (active_q.threshold),
        .out_valid (s3_valid),
        .out_tag   (s3_tag),
        .out_state (s3_state)
    );

    always_comb begin
        state_d   = state_q;
        shadow_d  = i_cmd_valid ? cmd_cfg : shadow_q;
        active_d  = active_q;
        ones_d    = ones_q;
        dec_d     = dec_q;
        dropped_d = dropped_q | (i_shot_start && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (i_shot_start) begin
                    state_d  = COLLECT;
                    active_d = load_cfg;
                    ones_d   = '0;
                    dec_d    = '0;
                end
            end
            COLLECT: begin
                // Untagged decisions belong to samples outside this shot.
                if (s3_valid && s3_tag) begin
                    dec_d  = dec_q + LEN_W'(1);
                    ones_d = ones_q + LEN_W'(s3_state);
                    if (dec_d >= len_eff) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            active_q  <= '0;
            ones_q    <= '0;
            dec_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            ones_q    <= ones_d;
            dec_q     <= dec_d;
            dropped_q <= dropped_d;
        end
    end

    assign o_busy         = (state_q != IDLE);
    assign o_valid        = (state_q == REPORT);
    assign o_sample_valid = s3_valid;
    assign o_sample_state = s3_state;
    assign o_ones_cnt     = ones_q;
    assign o_majority     = {ones_q, 1'b0} > {1'b0, len_eff};
    assign o_shot_dropped = dropped_q;

endmodule

// File: doc/iq_shot_discriminator.md
Name: iq_shot_discriminator

Overview:
- Downstream consumer of dsp_path. Takes the averaged I/Q stream (o_valid/o_data_i/o_data_q) and projects each sample onto a programmable axis (W_I*I + W_Q*Q).
- Thresholds each projection into a qubit-state bit, then counts the bits over a triggered shot window of N samples.
- Delivers one per-shot result record to the host readout logic over a valid/ready handshake.

Parameters:
- INT_IN_DATA_WIDTH, 23, signed I/Q width; equals dsp_path output width (20 + $clog2(5)).
- INT_WEIGHT_WIDTH, 16, signed width of W_I and W_Q.
- INT_MAX_SHOT_LEN, 1024, maximum decisions per shot.
- INT_PROJ_WIDTH, INT_IN_DATA_WIDTH+INT_WEIGHT_WIDTH+1 (=40), projection/threshold width; derived, do not override.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-low reset.
- i_valid  in  1  input sample strobe.
- i_data_i  in  INT_IN_DATA_WIDTH  signed I sample.
- i_data_q  in  INT_IN_DATA_WIDTH  signed Q sample.
- i_cmd_valid  in  1  load all config fields below into shadow registers.
- i_cmd_weight_i  in  INT_WEIGHT_WIDTH  signed W_I.
- i_cmd_weight_q  in  INT_WEIGHT_WIDTH  signed W_Q.
- i_cmd_threshold  in  INT_PROJ_WIDTH  signed threshold.
- i_cmd_shot_len  in  $clog2(INT_MAX_SHOT_LEN+1)  decisions per shot.
- i_shot_start  in  1  single-cycle shot trigger.
- i_ready  in  1  downstream accepts the result record.
- o_busy  out  1  high in COLLECT or REPORT.
- o_sample_valid  out  1  per-sample decision strobe.
- o_sample_state  out  1  per-sample decision bit.
- o_valid  out  1  result record valid.
- o_ones_cnt  out  $clog2(INT_MAX_SHOT_LEN+1)  count of state=1 decisions in the shot.
- o_majority  out  1  1 when 2*o_ones_cnt > active shot length.
- o_shot_dropped  out  1  sticky flag: trigger arrived while busy.

Behaviour:
- Reset (rst=0, async): FSM=IDLE. Shadow and active config cleared to 0. All outputs 0. Pipeline valid/tag bits cleared.
- Config: i_cmd_valid writes the shadow registers in any state. Shadow is copied to active config on the IDLE->COLLECT transition. If i_cmd_valid and i_shot_start coincide, the new cmd values are used for that shot (bypass). A shot_len of 0 is treated as 1.
- Pipeline, fixed 3-cycle latency from i_valid to o_sample_valid:
  - S1 registers I*W_I and Q*W_Q (full-precision signed).
  - S2 registers their sum (INT_PROJ_WIDTH, sign-extended, no truncation or saturation).
  - S3 registers state = (sum >= active threshold).
  - o_sample_valid/o_sample_state are driven from S3 in every FSM state.
- Tag bit travels with each sample. It is set when i_valid=1 and (FSM=COLLECT, or IDLE with i_shot_start=1 that cycle). Only tagged S3 decisions are counted.
- FSM:
  - IDLE: i_shot_start -> COLLECT; load active config; clear the ones and decision counters.
  - COLLECT: each tagged decision increments the decision counter and adds the state bit to ones. When the decision counter reaches the active length (including the current decision) -> REPORT. Tagged decisions still in flight after that are discarded.
  - REPORT: o_valid=1; o_ones_cnt and o_majority are held stable. On o_valid && i_ready -> IDLE, o_valid=0 next cycle.
  - i_shot_start in COLLECT or REPORT is ignored and sets o_shot_dropped. The flag clears only on reset.
- Backpressure: REPORT holds indefinitely. Input samples arriving in REPORT are processed by the pipeline (o_sample_* still strobes) but are not tagged.
- Reset asserted mid-shot aborts immediately. No partial record is emitted.

Decomposition:
- Shared package dsp_discr_pkg holds:
  - typedef enum {IDLE, COLLECT, REPORT} t_discr_state.
  - a width function for the projection width.
  - a config record struct (weight_i, weight_q, threshold, shot_len).
- One sub-module, iq_projection_mac: S1/S2/S3 pipeline with valid+tag passthrough.
- FSM and counters live in the top.

Test Plan:
- Basic shot: W_I=1, W_Q=0, thr=0, len=4. Trigger, then I=5,-3,7,0 on consecutive cycles -> o_sample_state 1,0,1,1 three cycles after each input; o_valid with o_ones_cnt=3, o_majority=1.
- Q-axis with negative weight: W_I=0, W_Q=-2, thr=-10, len=3. Q=4,6,5 -> projections -8,-12,-10 -> states 1,0,1; ones=2, majority=1.
- Full-scale no overflow: I=Q=-2^22, W_I=W_Q=-2^15, thr=2^38 -> projection exactly 2^38 -> state 1. Threshold 2^38+1 -> state 0.
- Backpressure and dropped trigger: hold i_ready=0 for 20 cycles in REPORT with i_shot_start pulsed -> record stable, o_shot_dropped=1, o_busy=1. After i_ready=1 -> IDLE, flag stays 1.
- Config bypass and len=0: i_cmd_valid with len=0 in the same cycle as i_shot_start -> exactly one decision counted. Samples valid before the trigger cycle are not counted.
- Async reset mid-COLLECT: drop rst for 1 ns at decision 2 of 4 -> all outputs 0 immediately, no o_valid. The next shot counts from zero.
